if_id_decode: RTL and testbench
===============================

# if_id_decode

IF/ID pipeline register and RV32I instruction decoder.
- Sits directly downstream of the fetch stage and captures the fetched `PC` and instruction each cycle.
- Decodes register fields, the sign-extended immediate and the main control signals, and presents them registered to the execute stage.
- Supports stall (hold) and flush (bubble insertion).
- Optionally resolves JAL early and drives the redirect inputs (`PC_immed`, `PCSrc`) back into fetch.

## Interface
Parameters:
- `NOP_INSN`, `32'h0000_0013`: encoding held in `o_instruction` for a bubble.

Ports:
- `i_clk`, in, 1: clock.
- `i_rstn`, in, 1: reset, asynchronous, active-low.
- `i_valid`, in, 1: fetch presents a real instruction this cycle.
- `i_PC`, in, 32: PC of the fetched instruction.
- `i_instruction`, in, 32: fetched instruction word.
- `i_stall`, in, 1: hold current contents (hazard unit).
- `i_flush`, in, 1: replace next contents with a bubble (branch mispredict).
- `o_valid`, out, 1: registered instruction is real.
- `o_PC`, out, 32: registered PC.
- `o_instruction`, out, 32: registered instruction word.
- `o_opcode` (7), `o_rd` (5), `o_rs1` (5), `o_rs2` (5), `o_funct3` (3), `o_funct7` (7), out: decoded fields.
- `o_imm`, out, 32: sign-extended immediate.
- `o_reg_write`, `o_mem_read`, `o_mem_write`, `o_branch`, `o_jump`, `o_alu_src`, `o_mem_to_reg`, out, 1 each: control signals.
- `o_illegal`, out, 1: unsupported encoding.
- `o_PC_immed`, out, 32: early JAL target, to fetch.
- `o_PCSrc`, out, 1: early redirect select, to fetch.

## Operation
- Decode is combinational from `i_instruction`; all decoded outputs are registered together with `o_PC` and `o_valid`.
- Immediate by opcode (`x` = instruction bits):
  - I-type (LOAD, OP-IMM, JALR): sext `x[31:20]`.
  - S-type: sext `{x[31:25], x[11:7]}`.
  - B-type: sext `{x[31], x[7], x[30:25], x[11:8], 0}`.
  - U-type (LUI, AUIPC): `{x[31:12], 12'b0}`.
  - J-type: sext `{x[31], x[19:12], x[20], x[30:21], 0}`.
  - R-type and other opcodes: 0.
- Control signals by opcode:
  - LOAD: `reg_write`, `mem_read`, `alu_src`, `mem_to_reg`.
  - STORE: `mem_write`, `alu_src`.
  - BRANCH: `branch`.
  - OP: `reg_write`.
  - OP-IMM, LUI, AUIPC: `reg_write`, `alu_src`.
  - JAL: `reg_write`, `jump`.
  - JALR: `reg_write`, `jump`, `alu_src`.
  - MISC-MEM, SYSTEM: all control 0 (architectural NOP).
- `o_reg_write` is forced to 0 when rd = 0.
- Illegal instruction:
  - Condition: `x[1:0]` ≠ `2'b11`, or the opcode is outside the eleven RV32I opcodes.
  - Response: `o_illegal` = 1, all control outputs 0, `o_valid` still reflects `i_valid`.
- A bubble has: `o_valid` = 0, `o_instruction` = `NOP_INSN`, `o_PC` = 0, all fields, immediate and control = 0, `o_illegal` = 0.
- `i_valid` = 0 captures a bubble.

## Timing
- Reset (asynchronous): all registered outputs hold bubble values; `o_PCSrc` = 0 and `o_PC_immed` = 0.
- Latency: one cycle. Inputs present at edge N appear at the outputs after edge N.
- Per-edge priority:
  1. `i_flush` = 1: capture a bubble, regardless of `i_stall`.
  2. `i_stall` = 1: hold all registers unchanged.
  3. Otherwise: capture the decoded inputs.
- Flush and stall in the same cycle: flush wins, and the stall is dropped for that edge.
- Reset deasserting mid-stream: the first capture happens on the first edge after deassertion; no partial state.
- No internal state beyond the pipeline register and, when enabled, the one-bit squash flag.

## Configuration
- Macro: `IFID_EARLY_JAL_EN`.
- Defined:
  - `o_PCSrc` = `o_valid` & (`o_opcode` == JAL) & ~`i_stall`, combinational from the registers.
  - `o_PC_immed` = `o_PC` + `o_imm`, modulo 2^32 with wrap-around.
  - When `o_PCSrc` = 1, the next non-stalled edge captures a bubble, squashing the sequential instruction already fetched. This is an internal squash, OR-ed with `i_flush`.
- Undefined: `o_PCSrc` = 0 and `o_PC_immed` = 0 constant; no squash logic is generated.

## Structure
- Shared package `rv32i_pkg` holds:
  - the eleven opcode localparams;
  - the default `NOP_INSN`;
  - a control-bundle struct/typedef, reused by execute.
- One sub-module: `imm_gen`, combinational, taking the instruction and producing the 32-bit immediate.
- The decoder and pipeline register stay in `if_id_decode`.

## Test plan
- **Reset:** assert `i_rstn` = 0 mid-capture of `0x00A00093`. Expect all outputs at bubble values immediately; `o_instruction` = `0x00000013`.
- **Load decode:** `i_valid` = 1, `i_PC` = `0x100`, instruction `0xFFC12083` (lw x1, -4(x2)). After one edge: rd = 1, rs1 = 2, imm = `0xFFFFFFFC`; `reg_write`, `mem_read`, `alu_src`, `mem_to_reg` = 1; `o_PC` = `0x100`.
- **Stall:** hold `i_stall` = 1 for 3 cycles while inputs change. Expect outputs frozen at the prior instruction; after release, the new instruction appears one edge later.
- **Flush and stall together:** `i_flush` = 1 and `i_stall` = 1 together. Expect `o_valid` = 0 next cycle.
- **Illegal encodings:**
  - instruction `0x0000007F`: expect `o_illegal` = 1, controls 0, `o_valid` = 1;
  - `0x00000000` (low bits ≠ 11): expect `o_illegal` = 1;
  - `addi x0, x0, 5`: expect `o_reg_write` = 0.
- **Early JAL (with `IFID_EARLY_JAL_EN`):** JAL at PC `0x200`, offset −8. Expect `o_PCSrc` = 1 and `o_PC_immed` = `0x1F8` during its decode cycle, and the following capture is a bubble. With `i_stall` = 1, expect `o_PCSrc` = 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I opcodes, default bubble encoding and inter-stage bundles.
// Imported by the IF/ID stage and reused downstream by execute.
package rv32i_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [31:0] DEFAULT_NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic alu_src;
        logic mem_to_reg;
    } ctrl_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        ctrl_t       ctrl;
        logic        illegal;
    } if_id_t;

endpackage

// File: rtl/if_id_decode_if.sv
// Fetch -> IF/ID handshake and decoded bundle towards execute.
// slave is the IF/ID stage view; master is the surrounding pipeline view.
interface if_id_decode_if;

    logic        i_valid;
    logic [31:0] i_PC;
    logic [31:0] i_instruction;
    logic        i_stall;
    logic        i_flush;

    logic        o_valid;
    logic [31:0] o_PC;
    logic [31:0] o_instruction;
    logic [6:0]  o_opcode;
    logic [4:0]  o_rd;
    logic [4:0]  o_rs1;
    logic [4:0]  o_rs2;
    logic [2:0]  o_funct3;
    logic [6:0]  o_funct7;
    logic [31:0] o_imm;
    logic        o_reg_write;
    logic        o_mem_read;
    logic        o_mem_write;
    logic        o_branch;
    logic        o_jump;
    logic        o_alu_src;
    logic        o_mem_to_reg;
    logic        o_illegal;
    logic [31:0] o_PC_immed;
    logic        o_PCSrc;

    modport slave (
        input  i_valid, i_PC, i_instruction, i_stall, i_flush,
        output o_valid, o_PC, o_instruction, o_opcode, o_rd, o_rs1,
        output o_rs2, o_funct3, o_funct7, o_imm, o_reg_write,
        output o_mem_read, o_mem_write, o_branch, o_jump, o_alu_src,
        output o_mem_to_reg, o_illegal, o_PC_immed, o_PCSrc
    );

    modport master (
        output i_valid, i_PC, i_instruction, i_stall, i_flush,
        input  o_valid, o_PC, o_instruction, o_opcode, o_rd, o_rs1,
        input  o_rs2, o_funct3, o_funct7, o_imm, o_reg_write,
        input  o_mem_read, o_mem_write, o_branch, o_jump, o_alu_src,
        input  o_mem_to_reg, o_illegal, o_PC_immed, o_PCSrc
    );

endinterface

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator, format selected by opcode.
import rv32i_pkg::*;

module imm_gen (
    input  logic [31:0] i_instruction,
    output logic [31:0] o_imm
);

    logic [31:0] x;
    assign x = i_instruction;

    always_comb begin
        o_imm = '0;
        case (x[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR:
                o_imm = {{20{x[31]}}, x[31:20]};
            OPC_STORE:
                o_imm = {{20{x[31]}}, x[31:25], x[11:7]};
            OPC_BRANCH:
                o_imm = {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                o_imm = {x[31:12], 12'b0};
            OPC_JAL:
                o_imm = {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
            default:
                o_imm = '0;
        endcase
    end

endmodule

// File: rtl/if_id_decode.sv
// IF/ID pipeline register with RV32I decode; stall holds, flush bubbles.
// Define IFID_EARLY_JAL_EN to resolve JAL here and redirect fetch early.
import rv32i_pkg::*;

module if_id_decode #(
    parameter logic [31:0] NOP_INSN = DEFAULT_NOP_INSN
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    if_id_decode_if.slave  bus
);

    if_id_t pipe_q, pipe_d;
    if_id_t dec;
    if_id_t bubble;
    logic [31:0] imm;
    logic        legal;
    logic        squash;

    imm_gen u_imm_gen (
        .i_instruction (bus.i_instruction),
        .o_imm         (imm)
    );

    always_comb begin
        bubble      = '0;
        bubble.insn = NOP_INSN;
    end

    always_comb begin
        dec         = '0;
        legal       = 1'b1;
        dec.valid   = 1'b1;
        dec.pc      = bus.i_PC;
        dec.insn    = bus.i_instruction;
        dec.opcode  = bus.i_instruction[6:0];
        dec.rd      = bus.i_instruction[11:7];
        dec.rs1     = bus.i_instruction[19:15];
        dec.rs2     = bus.i_instruction[24:20];
        dec.funct3  = bus.i_instruction[14:12];
        dec.funct7  = bus.i_instruction[31:25];
        dec.imm     = imm;
        case (dec.opcode)
            OPC_LOAD: begin
                dec.ctrl.reg_write  = 1'b1;
                dec.ctrl.mem_read   = 1'b1;
                dec.ctrl.alu_src    = 1'b1;
                dec.ctrl.mem_to_reg = 1'b1;
            end
            OPC_STORE: begin
                dec.ctrl.mem_write = 1'b1;
                dec.ctrl.alu_src   = 1'b1;
            end
            OPC_BRANCH: dec.ctrl.branch = 1'b1;
            OPC_OP:     dec.ctrl.reg_write = 1'b1;
            OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
                dec.ctrl.reg_write = 1'b1;
                dec.ctrl.alu_src   = 1'b1;
            end
            OPC_JAL: begin
                dec.ctrl.reg_write = 1'b1;
                dec.ctrl.jump      = 1'b1;
            end
            OPC_JALR: begin
                dec.ctrl.reg_write = 1'b1;
                dec.ctrl.jump      = 1'b1;
                dec.ctrl.alu_src   = 1'b1;
            end
            OPC_MISC_MEM, OPC_SYSTEM: dec.ctrl = '0;
            default: legal = 1'b0;
        endcase
        if (bus.i_instruction[1:0] != 2'b11) legal = 1'b0;
        if (!legal) dec.ctrl = '0;
        dec.illegal = !legal;
        // Writes to x0 are architecturally discarded; drop them at decode.
        if (dec.rd == 5'd0) dec.ctrl.reg_write = 1'b0;
    end

`ifdef IFID_EARLY_JAL_EN
    assign bus.o_PCSrc    = pipe_q.valid && (pipe_q.opcode == OPC_JAL)
                            && !bus.i_stall;
    assign bus.o_PC_immed = pipe_q.pc + pipe_q.imm;
    // The redirect edge also kills the sequential fetch behind the JAL.
    assign squash         = bus.o_PCSrc;
`else
    assign bus.o_PCSrc    = 1'b0;
    assign bus.o_PC_immed = '0;
    assign squash         = 1'b0;
`endif

    always_comb begin
        pipe_d = pipe_q;
        if (bus.i_flush || squash) begin
            pipe_d = bubble;
        end else if (!bus.i_stall) begin
            pipe_d = bus.i_valid ? dec : bubble;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pipe_q      <= '0;
            pipe_q.insn <= NOP_INSN;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign bus.o_valid       = pipe_q.valid;
    assign bus.o_PC          = pipe_q.pc;
    assign bus.o_instruction = pipe_q.insn;
    assign bus.o_opcode      = pipe_q.opcode;
    assign bus.o_rd          = pipe_q.rd;
    assign bus.o_rs1         = pipe_q.rs1;
    assign bus.o_rs2         = pipe_q.rs2;
    assign bus.o_funct3      = pipe_q.funct3;
    assign bus.o_funct7      = pipe_q.funct7;
    assign bus.o_imm         = pipe_q.imm;
    assign bus.o_reg_write   = pipe_q.ctrl.reg_write;
    assign bus.o_mem_read    = pipe_q.ctrl.mem_read;
    assign bus.o_mem_write   = pipe_q.ctrl.mem_write;
    assign bus.o_branch      = pipe_q.ctrl.branch;
    assign bus.o_jump        = pipe_q.ctrl.jump;
    assign bus.o_alu_src     = pipe_q.ctrl.alu_src;
    assign bus.o_mem_to_reg  = pipe_q.ctrl.mem_to_reg;
    assign bus.o_illegal     = pipe_q.illegal;

endmodule

// File: tb/tb_if_id_decode.sv
// Directed self-checking bench for the IF/ID decode stage.
// Expected values are hand-derived from the RV32I encodings used.
module tb_if_id_decode;

    logic i_clk;
    logic i_rstn;
    int   tests;
    int   fails;

    if_id_decode_if bus ();

    if_id_decode dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .bus    (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic [31:0] insn);
        bus.i_valid       = v;
        bus.i_PC          = pc;
        bus.i_instruction = insn;
    endtask

    function automatic logic [6:0] ctrl_vec();
        return {bus.o_reg_write, bus.o_mem_read, bus.o_mem_write,
                bus.o_branch, bus.o_jump, bus.o_alu_src, bus.o_mem_to_reg};
    endfunction

    task automatic test_reset();
        drive(1'b1, 32'h0, 32'h00A0_0093);
        tick();
        tests++;
        if (bus.o_rd !== 5'd1 || bus.o_imm !== 32'd10 || bus.o_valid !== 1'b1) begin
            fails++;
            $display("FAIL addi_pre_reset: rd=%0d imm=%h v=%b want rd=1 imm=0000000a v=1",
                     bus.o_rd, bus.o_imm, bus.o_valid);
        end
        @(negedge i_clk);
        i_rstn = 1'b0;
        #1;
        tests++;
        if (bus.o_valid !== 1'b0 || bus.o_instruction !== 32'h13 || bus.o_PC !== 0) begin
            fails++;
            $display("FAIL reset_bubble: v=%b insn=%h pc=%h want 0/00000013/0",
                     bus.o_valid, bus.o_instruction, bus.o_PC);
        end
        tests++;
        if (bus.o_rd !== 0 || bus.o_imm !== 0 || ctrl_vec() !== 0 ||
            bus.o_illegal !== 0 || bus.o_opcode !== 0) begin
            fails++;
            $display("FAIL reset_fields: rd=%0d imm=%h ctrl=%b ill=%b want all 0",
                     bus.o_rd, bus.o_imm, ctrl_vec(), bus.o_illegal);
        end
        tests++;
        if (bus.o_PCSrc !== 1'b0 || bus.o_PC_immed !== 0) begin
            fails++;
            $display("FAIL reset_redirect: pcsrc=%b target=%h want 0/0",
                     bus.o_PCSrc, bus.o_PC_immed);
        end
        tick();
        i_rstn = 1'b1;
    endtask

    task automatic test_load();
        drive(1'b1, 32'h100, 32'hFFC1_2083);
        tick();
        tests++;
        if (bus.o_rd !== 5'd1 || bus.o_rs1 !== 5'd2 || bus.o_imm !== 32'hFFFF_FFFC) begin
            fails++;
            $display("FAIL load_fields: rd=%0d rs1=%0d imm=%h want 1/2/fffffffc",
                     bus.o_rd, bus.o_rs1, bus.o_imm);
        end
        tests++;
        if (ctrl_vec() !== 7'b1100011 || bus.o_PC !== 32'h100 ||
            bus.o_funct3 !== 3'd2 || bus.o_illegal !== 1'b0) begin
            fails++;
            $display("FAIL load_ctrl: ctrl=%b pc=%h f3=%0d ill=%b want 1100011/100/2/0",
                     ctrl_vec(), bus.o_PC, bus.o_funct3, bus.o_illegal);
        end
    endtask

    task automatic test_stall();
        bus.i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h104 + 32'(i * 4), 32'h0053_2423);
            tick();
            tests++;
            if (bus.o_instruction !== 32'hFFC1_2083 || bus.o_PC !== 32'h100 ||
                ctrl_vec() !== 7'b1100011) begin
                fails++;
                $display("FAIL stall_hold%0d: insn=%h pc=%h ctrl=%b want ffc12083/100/1100011",
                         i, bus.o_instruction, bus.o_PC, ctrl_vec());
            end
        end
        bus.i_stall = 1'b0;
        drive(1'b1, 32'h104, 32'h0053_2423);
        tick();
        tests++;
        if (ctrl_vec() !== 7'b0010010 || bus.o_imm !== 32'd8 || bus.o_rs2 !== 5'd5 ||
            bus.o_rs1 !== 5'd6 || bus.o_PC !== 32'h104) begin
            fails++;
            $display("FAIL store_after_stall: ctrl=%b imm=%h rs2=%0d rs1=%0d pc=%h want 0010010/8/5/6/104",
                     ctrl_vec(), bus.o_imm, bus.o_rs2, bus.o_rs1, bus.o_PC);
        end
    endtask

    task automatic test_flush_stall();
        bus.i_flush = 1'b1;
        bus.i_stall = 1'b1;
        drive(1'b1, 32'h108, 32'h00A0_0093);
        tick();
        bus.i_flush = 1'b0;
        bus.i_stall = 1'b0;
        tests++;
        if (bus.o_valid !== 1'b0 || bus.o_instruction !== 32'h13 ||
            bus.o_PC !== 0 || ctrl_vec() !== 0) begin
            fails++;
            $display("FAIL flush_stall: v=%b insn=%h pc=%h ctrl=%b want 0/00000013/0/0",
                     bus.o_valid, bus.o_instruction, bus.o_PC, ctrl_vec());
        end
        drive(1'b0, 32'h10C, 32'h00A0_0093);
        tick();
        tests++;
        if (bus.o_valid !== 1'b0 || bus.o_rd !== 0 || bus.o_PC !== 0) begin
            fails++;
            $display("FAIL invalid_bubble: v=%b rd=%0d pc=%h want 0/0/0",
                     bus.o_valid, bus.o_rd, bus.o_PC);
        end
    endtask

    task automatic test_illegal();
        drive(1'b1, 32'h110, 32'h0000_007F);
        tick();
        tests++;
        if (bus.o_illegal !== 1'b1 || ctrl_vec() !== 0 || bus.o_valid !== 1'b1) begin
            fails++;
            $display("FAIL illegal_opc: ill=%b ctrl=%b v=%b want 1/0/1",
                     bus.o_illegal, ctrl_vec(), bus.o_valid);
        end
        drive(1'b1, 32'h114, 32'h0000_0000);
        tick();
        tests++;
        if (bus.o_illegal !== 1'b1 || ctrl_vec() !== 0) begin
            fails++;
            $display("FAIL illegal_low: ill=%b ctrl=%b want 1/0",
                     bus.o_illegal, ctrl_vec());
        end
        drive(1'b1, 32'h118, 32'h0050_0013);
        tick();
        tests++;
        if (bus.o_reg_write !== 1'b0 || bus.o_alu_src !== 1'b1 ||
            bus.o_imm !== 32'd5 || bus.o_illegal !== 1'b0) begin
            fails++;
            $display("FAIL addi_x0: rw=%b as=%b imm=%h ill=%b want 0/1/5/0",
                     bus.o_reg_write, bus.o_alu_src, bus.o_imm, bus.o_illegal);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h11C, 32'hFE20_8EE3);
        tick();
        tests++;
        if (bus.o_imm !== 32'hFFFF_FFFC || ctrl_vec() !== 7'b0001000 ||
            bus.o_rs1 !== 5'd1 || bus.o_rs2 !== 5'd2) begin
            fails++;
            $display("FAIL beq: imm=%h ctrl=%b rs1=%0d rs2=%0d want fffffffc/0001000/1/2",
                     bus.o_imm, ctrl_vec(), bus.o_rs1, bus.o_rs2);
        end
        drive(1'b1, 32'h120, 32'h1234_51B7);
        tick();
        tests++;
        if (bus.o_imm !== 32'h1234_5000 || ctrl_vec() !== 7'b1000010 ||
            bus.o_rd !== 5'd3 || bus.o_PC !== 32'h120) begin
            fails++;
            $display("FAIL lui: imm=%h ctrl=%b rd=%0d pc=%h want 12345000/1000010/3/120",
                     bus.o_imm, ctrl_vec(), bus.o_rd, bus.o_PC);
        end
    endtask

    task automatic test_jal();
        drive(1'b1, 32'h200, 32'hFF9F_F0EF);
        tick();
        tests++;
        if (bus.o_imm !== 32'hFFFF_FFF8 || ctrl_vec() !== 7'b1000100 ||
            bus.o_opcode !== 7'b1101111) begin
            fails++;
            $display("FAIL jal_decode: imm=%h ctrl=%b opc=%b want fffffff8/1000100/1101111",
                     bus.o_imm, ctrl_vec(), bus.o_opcode);
        end
        drive(1'b1, 32'h204, 32'h00A0_0093);
`ifdef IFID_EARLY_JAL_EN
        bus.i_stall = 1'b1;
        #1;
        tests++;
        if (bus.o_PCSrc !== 1'b0) begin
            fails++;
            $display("FAIL jal_stalled: pcsrc=%b want 0", bus.o_PCSrc);
        end
        bus.i_stall = 1'b0;
        #1;
        tests++;
        if (bus.o_PCSrc !== 1'b1 || bus.o_PC_immed !== 32'h1F8) begin
            fails++;
            $display("FAIL jal_redirect: pcsrc=%b target=%h want 1/000001f8",
                     bus.o_PCSrc, bus.o_PC_immed);
        end
        tick();
        tests++;
        if (bus.o_valid !== 1'b0 || bus.o_instruction !== 32'h13 || bus.o_PCSrc !== 1'b0) begin
            fails++;
            $display("FAIL jal_squash: v=%b insn=%h pcsrc=%b want 0/00000013/0",
                     bus.o_valid, bus.o_instruction, bus.o_PCSrc);
        end
`else
        #1;
        tests++;
        if (bus.o_PCSrc !== 1'b0 || bus.o_PC_immed !== 0) begin
            fails++;
            $display("FAIL jal_no_redirect: pcsrc=%b target=%h want 0/0",
                     bus.o_PCSrc, bus.o_PC_immed);
        end
        tick();
        tests++;
        if (bus.o_valid !== 1'b1 || bus.o_PC !== 32'h204) begin
            fails++;
            $display("FAIL jal_no_squash: v=%b pc=%h want 1/204",
                     bus.o_valid, bus.o_PC);
        end
`endif
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        i_rstn      = 1'b0;
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        repeat (2) tick();
        i_rstn = 1'b1;
        test_reset();
        test_load();
        test_stall();
        test_flush_stall();
        test_illegal();
        test_back_to_back();
        test_jal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
